qosc_tuner: RTL
===============

// Module: qosc_tuner
// PURPOSE
//  Converts a requested LO frequency in Hz into the reload word for the quadrature oscillator controller.
//  Sits directly upstream of it: o_reload/o_we drive its i_reload/i_we.
//  Division is a sequential restoring divider, one quotient bit per cycle, all in the i_clk domain.
// PARAMETERS
//  PLL_HZ        400_000_000  PLL clock frequency in Hz; 32-bit constant; dividend of the division
//  MIN_RELOAD    1            smallest reload ever issued; lower results are clamped to it
//  RESET_RELOAD  63           o_reload value after reset; matches the oscillator's power-up reload
//  WE_HOLD       4            cycles o_we stays high (min 3); lets the PLL-domain synchroniser see it
// PORTS
//  i_clk      in   1   system clock
//  i_rst      in   1   asynchronous, active-high reset
//  i_valid    in   1   request strobe; accepted when i_valid && o_ready
//  i_freq     in   32  requested LO frequency, Hz, unsigned
//  o_ready    out  1   idle, able to accept a request
//  o_we       out  1   write enable to the oscillator, held for WE_HOLD cycles
//  o_reload   out  32  reload word; registered; stable from o_we rise until the next write
//  o_clamped  out  1   last issued reload was clamped to MIN_RELOAD; updated with each write
//  o_err      out  1   1-cycle pulse: request with i_freq==0 was rejected
// BEHAVIOUR
//  - Reset (async assert, sync release) puts the FSM in IDLE and sets the outputs:
//    o_ready=1, o_we=0, o_reload=RESET_RELOAD, o_clamped=0, o_err=0.
//  - Target relation: one ring step = reload+1 PLL cycles, so reload = q-1.
//    Here q = floor(D / (4*i_freq)), with D = PLL_HZ zero-extended to 34 bits.
//  - FSM IDLE -> DIV -> FIN -> WRITE -> IDLE.
//  - IDLE: o_ready=1.
//    - On accept (cycle N), latch divisor = {i_freq,2'b00} (34 bit) and the dividend.
//    - i_freq==0: stay in IDLE, pulse o_err at N+1, leave o_reload/o_clamped unchanged.
//  - DIV: 34 iterations, cycles N+1..N+34.
//    - Each cycle: 35-bit partial remainder shifted left by one, divisor trial-subtracted, one quotient bit produced.
//    - o_ready=0; i_valid is ignored and is not queued.
//  - FIN (N+35): r = q-1 in 34 bits.
//    - If q==0 or r < MIN_RELOAD: o_reload <= MIN_RELOAD and o_clamped <= 1.
//    - Else o_reload <= r[31:0] and o_clamped <= 0.
//    - r never exceeds 32 bits because PLL_HZ < 2^32.
//  - WRITE: o_we=1 for cycles N+36..N+35+WE_HOLD. o_reload is already valid at the o_we rise.
//    - Returns to IDLE afterwards; o_ready=1 from N+36+WE_HOLD.
//  - Accept-to-o_we latency is exactly 36 cycles, regardless of operand values.
//  - o_we is glitch-free, driven straight from a flop.
//  - Back-to-back requests are each written fully, in order. No request is ever dropped while o_ready=1.
//  - Reset mid-operation (any state) aborts: o_we drops immediately and o_reload returns to RESET_RELOAD.
// CONFIGURATION
//  - QOSC_TUNER_ROUND_EN defined: dividend D = PLL_HZ + 2*i_freq (34 bit, no overflow), giving round-to-nearest q.
//  - Not defined: D = PLL_HZ, truncating division.
//  - Latency, ports and clamping are identical in both builds.
// TESTING
//  - PLL_HZ=400e6, i_freq=1_000_000 -> o_we at N+36, o_reload=99, o_clamped=0.
//  - i_freq=5_700_000 -> o_reload=16; with QOSC_TUNER_ROUND_EN -> o_reload=17.
//  - i_freq=100_000_000 -> q=1, r=0, o_reload=1, o_clamped=1.
//    - Then i_freq=50_000_000 -> o_reload=1, o_clamped=0.
//  - i_freq=0 -> o_err high exactly one cycle, no o_we, o_reload keeps its previous value, o_ready stays 1.
//  - i_freq=1 -> o_reload=99_999_999.
//    - A second i_valid during DIV is ignored; only one o_we burst of WE_HOLD cycles is seen.
//  - i_rst pulsed at N+20 -> o_we never rises, o_reload=63, o_ready=1 after release.
//    - A new request then completes normally.

Source files
------------

// File: rtl/qosc_tuner.sv
// Converts a requested LO frequency into the oscillator reload word using a 34-step restoring divider.
// Optional build macro QOSC_TUNER_ROUND_EN selects a round-to-nearest quotient.
module qosc_tuner #(
    parameter logic [31:0] PLL_HZ       = 32'd400_000_000,
    parameter logic [31:0] MIN_RELOAD   = 32'd1,
    parameter logic [31:0] RESET_RELOAD = 32'd63,
    parameter int unsigned WE_HOLD      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_freq,
    output logic        o_ready,
    output logic        o_we,
    output logic [31:0] o_reload,
    output logic        o_clamped,
    output logic        o_err
);

    typedef enum logic [1:0] {IDLE, DIV, FIN, WRITE} state_t;

    localparam int unsigned DIV_STEPS = 34;

    state_t      state, state_next;
    logic [31:0] cnt;
    logic [33:0] divisor;
    logic [33:0] quot;
    logic [33:0] rem;
    logic [33:0] dividend;
    logic [34:0] rem_sh;
    logic [33:0] diff;
    logic        ge;
    logic [33:0] r_sub;
    logic        clamp;

`ifdef QOSC_TUNER_ROUND_EN
    // Adding half the divisor (2*f of 4*f) before truncation rounds to nearest.
    assign dividend = {2'b00, PLL_HZ} + {1'b0, i_freq, 1'b0};
`else
    assign dividend = {2'b00, PLL_HZ};
`endif

    // Dividend bits shift out of the top of quot while quotient bits enter at the bottom.
    assign rem_sh = {rem, quot[33]};
    assign ge     = rem_sh >= {1'b0, divisor};
    assign diff   = rem_sh[33:0] - divisor;

    assign r_sub  = quot - 34'd1;
    assign clamp  = (quot == '0) || (r_sub < {2'b00, MIN_RELOAD});

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_valid && (i_freq != '0)) begin
                    state_next = DIV;
                end
            end
            DIV: begin
                if (cnt == DIV_STEPS - 1) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = WRITE;
            end
            WRITE: begin
                if (cnt == WE_HOLD - 1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt       <= '0;
            divisor   <= '0;
            quot      <= '0;
            rem       <= '0;
            o_we      <= 1'b0;
            o_reload  <= RESET_RELOAD;
            o_clamped <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_err <= 1'b0;
            o_we  <= (state_next == WRITE);
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        if (i_freq == '0) begin
                            o_err <= 1'b1;
                        end else begin
                            divisor <= {i_freq, 2'b00};
                            quot    <= dividend;
                            rem     <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                DIV: begin
                    rem  <= ge ? diff : rem_sh[33:0];
                    quot <= {quot[32:0], ge};
                    cnt  <= cnt + 32'd1;
                end
                FIN: begin
                    cnt <= '0;
                    if (clamp) begin
                        o_reload  <= MIN_RELOAD;
                        o_clamped <= 1'b1;
                    end else begin
                        o_reload  <= r_sub[31:0];
                        o_clamped <= 1'b0;
                    end
                end
                WRITE: begin
                    cnt <= cnt + 32'd1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule
